md_sched: RTL and testbench

//   Sequencer for the EX-stage multiply/divide resource. Accepts one md op per issue from EX,

---
 rtl/md_sched_pkg.sv | 24 ++
 rtl/md_arith.sv | 75 +++++++
 rtl/md_sched.sv | 112 +++++++++++
 tb/tb_md_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/md_sched_pkg.sv
// rtl/md_sched_pkg.sv - md op encodings, sequencer state encoding and default latencies
package md_sched_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_MFHI  = 3'd6,
      OP_MFLO  = 3'd7
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   localparam int DEF_MULT_LAT = 5;
   localparam int DEF_DIV_LAT  = 10;
   localparam int DEF_CNT_W    = 4;

endpackage

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational 64-bit multiply / 32-bit divide on latched operands
module md_arith
   import md_sched_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        wr_en
);

   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic [31:0]        q_s, r_s, q_u, r_u;
   logic               div_zero, div_ovf;

   assign prod_s   = $signed(a) * $signed(b);
   assign prod_u   = {32'b0, a} * {32'b0, b};
   assign div_zero = (b == 32'd0);
   assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

   // The most-negative / -1 quotient does not fit a signed divide, so it is pinned directly.
   always_comb begin
      q_s = '0;
      r_s = '0;
      q_u = '0;
      r_u = '0;
      if (!div_zero) begin
         q_u = a / b;
         r_u = a % b;
         if (div_ovf) begin
            q_s = 32'h8000_0000;
            r_s = '0;
         end else begin
            q_s = $signed(a) / $signed(b);
            r_s = $signed(a) % $signed(b);
         end
      end
   end

   always_comb begin
      hi    = '0;
      lo    = '0;
      wr_en = 1'b0;
      case (op)
         OP_MULT: begin
            hi    = prod_s[63:32];
            lo    = prod_s[31:0];
            wr_en = 1'b1;
         end
         OP_MULTU: begin
            hi    = prod_u[63:32];
            lo    = prod_u[31:0];
            wr_en = 1'b1;
         end
         OP_DIV: begin
            hi    = r_s;
            lo    = q_s;
            wr_en = !div_zero;
         end
         OP_DIVU: begin
            hi    = r_u;
            lo    = q_u;
            wr_en = !div_zero;
         end
         default: begin
            hi    = '0;
            lo    = '0;
            wr_en = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/md_sched.sv
// rtl/md_sched.sv - EX-stage mult/div sequencer owning HI/LO; MD_FLUSH_EN adds the flush abort port
module md_sched
   import md_sched_pkg::*;
#(
   parameter int MULT_LAT = DEF_MULT_LAT,
   parameter int DIV_LAT  = DEF_DIV_LAT,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        d_is_md,
`ifdef MD_FLUSH_EN
   input  logic        flush,
`endif
   output logic        start,
   output logic        busy,
   output logic        stall_D,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_out
);

   md_state_e         state;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        op_q;
   logic [31:0]       a_q, b_q;
   logic [31:0]       res_hi, res_lo;
   logic              res_wr;
   logic              kill;

`ifdef MD_FLUSH_EN
   assign kill = flush;
`else
   assign kill = 1'b0;
`endif

   md_arith u_arith (
      .op    (op_q),
      .a     (a_q),
      .b     (b_q),
      .hi    (res_hi),
      .lo    (res_lo),
      .wr_en (res_wr)
   );

   assign start   = op_valid && (md_op <= OP_DIVU) && (state == ST_IDLE);
   assign stall_D = d_is_md && (start || busy);

   always_comb begin
      md_out = '0;
      if (md_op == OP_MFHI)
         md_out = hi;
      else if (md_op == OP_MFLO)
         md_out = lo;
   end

   // Kill outranks both a new start and the final commit edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         cnt   <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         hi    <= '0;
         lo    <= '0;
      end else if (kill) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_BUSY;
                  busy  <= 1'b1;
                  cnt   <= md_op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                  op_q  <= md_op;
                  a_q   <= rs_val;
                  b_q   <= rt_val;
               end else if (op_valid && md_op == OP_MTHI) begin
                  hi <= rs_val;
               end else if (op_valid && md_op == OP_MTLO) begin
                  lo <= rs_val;
               end
            end
            ST_BUSY: begin
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  if (res_wr) begin
                     hi <= res_hi;
                     lo <= res_lo;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - randomized bench for md_sched against a transaction-level HI/LO model
module tb_md_sched;

   localparam int ML = 5;
   localparam int DL = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic [2:0]  md_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        d_is_md;
`ifdef MD_FLUSH_EN
   logic        flush;
`endif
   logic        start;
   logic        busy;
   logic        stall_D;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] md_out;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] m_hi, m_lo;

   always #5 clk = ~clk;

   md_sched #(.MULT_LAT(ML), .DIV_LAT(DL), .CNT_W(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .op_valid (op_valid),
      .md_op    (md_op),
      .rs_val   (rs_val),
      .rt_val   (rt_val),
      .d_is_md  (d_is_md),
`ifdef MD_FLUSH_EN
      .flush    (flush),
`endif
      .start    (start),
      .busy     (busy),
      .stall_D  (stall_D),
      .hi       (hi),
      .lo       (lo),
      .md_out   (md_out)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   // Architectural result of one mult/div op, computed with wide integer arithmetic.
   function automatic void ref_exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      case (op)
         3'd0: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
         3'd1: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
         3'd2: if (b != 0) begin
            q = sa / sb; r = sa % sb;
            m_lo = q[31:0]; m_hi = r[31:0];
         end
         default: if (b != 0) begin
            m_lo = a / b; m_hi = a % b;
         end
      endcase
   endfunction

   function automatic logic [31:0] pick_operand;
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         4: return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] old_hi, old_lo;
      logic        d;
      int          lat;
      old_hi = m_hi;
      old_lo = m_lo;
      lat = (op >= 3'd2) ? DL : ML;
      d = 1'($urandom_range(0, 1));
      op_valid = 1'b1; md_op = op; rs_val = a; rt_val = b; d_is_md = d;
      @(negedge clk);
      check("start_pulse", 32'(start), 32'd1);
      check("busy_at_start", 32'(busy), 32'd0);
      check("stall_at_start", 32'(stall_D), 32'(d));
      check("md_out_non_mf", md_out, 32'd0);
      next_cycle;
      op_valid = 1'b0;
      md_op = 3'($urandom_range(0, 5));
      rs_val = $urandom;
      rt_val = $urandom;
      ref_exec(op, a, b);
      for (int k = 1; k <= lat; k++) begin
         d = 1'($urandom_range(0, 1));
         d_is_md = d;
         @(negedge clk);
         check("busy_window", 32'(busy), 32'd1);
         check("start_in_busy", 32'(start), 32'd0);
         check("stall_in_busy", 32'(stall_D), 32'(d));
         check("hi_held", hi, old_hi);
         check("lo_held", lo, old_lo);
         next_cycle;
      end
      d_is_md = 1'b1;
      @(negedge clk);
      check("busy_after", 32'(busy), 32'd0);
      check("stall_after", 32'(stall_D), 32'd0);
      check("hi_result", hi, m_hi);
      check("lo_result", lo, m_lo);
      next_cycle;
   endtask

   task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
      op_valid = 1'b1; md_op = op; rs_val = a; d_is_md = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("mt_no_start", 32'(start), 32'd0);
      check("mt_no_stall", 32'(stall_D), 32'd0);
      next_cycle;
      op_valid = 1'b0;
      if (op == 3'd4) m_hi = a; else m_lo = a;
      @(negedge clk);
      check("mt_busy", 32'(busy), 32'd0);
      check("mt_hi", hi, m_hi);
      check("mt_lo", lo, m_lo);
      next_cycle;
   endtask

   task automatic run_mf(input logic [2:0] op);
      op_valid = 1'b1; md_op = op;
      @(negedge clk);
      check("mf_value", md_out, (op == 3'd6) ? m_hi : m_lo);
      check("mf_no_start", 32'(start), 32'd0);
      next_cycle;
      op_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; op_valid = 1'b0; md_op = 3'd0; rs_val = '0; rt_val = '0; d_is_md = 1'b1;
`ifdef MD_FLUSH_EN
      flush = 1'b0;
`endif
      m_hi = '0; m_lo = '0;
      next_cycle;
      next_cycle;
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_start", 32'(start), 32'd0);
      check("rst_stall", 32'(stall_D), 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      next_cycle;

      run_md(3'd0, 32'hFFFF_FFFE, 32'd3);
      check("ex_mult_hi", hi, 32'hFFFF_FFFF);
      check("ex_mult_lo", lo, 32'hFFFF_FFFA);
      run_md(3'd3, 32'd100, 32'd7);
      check("ex_divu_lo", lo, 32'd14);
      check("ex_divu_hi", hi, 32'd2);
      run_md(3'd2, -32'd7, 32'd2);
      check("ex_div_lo", lo, -32'd3);
      check("ex_div_hi", hi, -32'd1);
      run_mt(3'd4, 32'h1234);
      run_mf(3'd6);
      run_mf(3'd7);
      run_md(3'd2, 32'd55, 32'd0);
      check("div0_hi", hi, 32'h1234);
      check("div0_lo", lo, -32'd3);
      run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      check("ovf_lo", lo, 32'h8000_0000);
      check("ovf_hi", hi, 32'd0);

      // Reset landing in the third busy cycle of a divide.
      run_mt(3'd4, 32'hDEAD_BEEF);
      run_mt(3'd5, 32'h5555);
      op_valid = 1'b1; md_op = 3'd3; rs_val = 32'd9; rt_val = 32'd2;
      next_cycle;
      op_valid = 1'b0;
      next_cycle;
      next_cycle;
      reset = 1'b1;
      next_cycle;
      reset = 1'b0;
      m_hi = '0; m_lo = '0;
      @(negedge clk);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_hi", hi, 32'd0);
      check("midrst_lo", lo, 32'd0);
      next_cycle;

`ifdef MD_FLUSH_EN
      run_mt(3'd4, 32'hA5A5);
      op_valid = 1'b1; md_op = 3'd0; rs_val = 32'd7; rt_val = 32'd9;
      next_cycle;
      op_valid = 1'b0;
      next_cycle;
      flush = 1'b1;
      next_cycle;
      flush = 1'b0;
      @(negedge clk);
      check("flush_busy", 32'(busy), 32'd0);
      check("flush_hi", hi, m_hi);
      check("flush_lo", lo, m_lo);
      for (int k = 0; k < ML + 2; k++) next_cycle;
      @(negedge clk);
      check("flush_hi_later", hi, m_hi);
      check("flush_lo_later", lo, m_lo);
      next_cycle;
`endif

      for (int i = 0; i < 40; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r <= 5)
            run_md(3'(r % 4), pick_operand(), pick_operand());
         else if (r <= 7)
            run_mt(3'(4 + (r - 6)), $urandom);
         else
            run_mf(3'(6 + (r - 8)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
